// File: rtl/cart_bus_if.sv
// Host-side request/response handshake for the cartridge bus master.
// The master modport is the host; the slave modport is cart_bus_master.
interface cart_bus_if;
  logic        req;
  logic        ready;
  logic        req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        done;
  logic [7:0]  rdata;

  modport master (output req, req_rw, req_addr, req_wdata, input ready, done, rdata);
  modport slave  (input req, req_rw, req_addr, req_wdata, output ready, done, rdata);
endinterface

// File: rtl/cart_bus_master.sv
// Famicom cartridge-edge initiator: free-running M2 with one CPU bus cycle per period.
// Define CART_BUS_PPU_EN to add the independent PPU read strobe port.
module cart_bus_master #(
  parameter int unsigned M2_LOW       = 4,
  parameter int unsigned M2_HIGH      = 6,
  parameter int unsigned ROMSEL_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  cart_bus_if.slave   host,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in
`ifdef CART_BUS_PPU_EN
  ,
  input  logic        ppu_req,
  output logic        ppu_ready,
  input  logic [13:0] ppu_req_addr,
  output logic        ppu_done,
  output logic [7:0]  ppu_rdata,
  output logic        ppu_rd,
  output logic [13:0] ppu_addr,
  output logic        ppu_not_a13,
  input  logic [7:0]  ppu_data_in
`endif
);

  localparam int unsigned CNT_MAX = (M2_LOW > M2_HIGH) ? M2_LOW : M2_HIGH;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic             phase_high;
  logic             phase_high_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rise_edge;
  logic             fall_edge;
  logic             lat_rw;
  logic             lat_rom;
  logic [7:0]       lat_wdata;

  // Phase counter: LOW 0..M2_LOW-1, then HIGH 0..M2_HIGH-1, forever.
  always_comb begin
    phase_high_nxt = phase_high;
    cnt_nxt        = cnt + CNT_W'(1);
    rise_edge      = 1'b0;
    fall_edge      = 1'b0;
    if (!phase_high && cnt == CNT_W'(M2_LOW - 1)) begin
      phase_high_nxt = 1'b1;
      cnt_nxt        = '0;
      rise_edge      = 1'b1;
    end else if (phase_high && cnt == CNT_W'(M2_HIGH - 1)) begin
      phase_high_nxt = 1'b0;
      cnt_nxt        = '0;
      fall_edge      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase_high   <= 1'b0;
      cnt          <= '0;
      m2           <= 1'b0;
      romsel       <= 1'b1;
      cpu_rw       <= 1'b1;
      cpu_addr     <= '0;
      cpu_data_out <= '0;
      cpu_data_oe  <= 1'b0;
      host.ready   <= 1'b0;
      host.done    <= 1'b0;
      host.rdata   <= '0;
      lat_rw       <= 1'b1;
      lat_rom      <= 1'b0;
      lat_wdata    <= '0;
    end else begin
      phase_high <= phase_high_nxt;
      cnt        <= cnt_nxt;
      m2         <= phase_high_nxt;
      host.ready <= phase_high_nxt && (cnt_nxt == CNT_W'(M2_HIGH - 1));
      host.done  <= 1'b0;

      // M2 fall closes the current cycle and may open the next one on the same edge.
      if (fall_edge) begin
        romsel    <= 1'b1;
        host.done <= (state == ACTIVE);
        if (state == ACTIVE && lat_rw) host.rdata <= cpu_data_in;
        if (host.req && host.ready) begin
          state     <= ACTIVE;
          lat_rw    <= host.req_rw;
          lat_rom   <= host.req_addr[15];
          lat_wdata <= host.req_wdata;
          cpu_addr  <= host.req_addr[14:0];
          cpu_rw    <= host.req_rw;
        end else begin
          state  <= IDLE;
          cpu_rw <= 1'b1;
        end
      end

      if (state == ACTIVE && lat_rom && phase_high_nxt && cnt_nxt == CNT_W'(ROMSEL_DELAY))
        romsel <= 1'b0;

      // Write data is held one clk past M2 fall unless another write follows.
      if (rise_edge && state == ACTIVE && !lat_rw) begin
        cpu_data_oe  <= 1'b1;
        cpu_data_out <= lat_wdata;
      end else if (!phase_high && cnt == '0 && !(state == ACTIVE && !lat_rw)) begin
        cpu_data_oe <= 1'b0;
      end
    end
  end

`ifdef CART_BUS_PPU_EN
  typedef enum logic [1:0] {P_IDLE, P_STROBE, P_RECOVER} ppu_state_t;

  ppu_state_t ppu_state;
  logic [1:0] ppu_cnt;

  // PPU read: 3-clk /RD strobe, then 1 clk of recovery before the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ppu_state   <= P_IDLE;
      ppu_cnt     <= '0;
      ppu_ready   <= 1'b1;
      ppu_done    <= 1'b0;
      ppu_rdata   <= '0;
      ppu_rd      <= 1'b1;
      ppu_addr    <= '0;
      ppu_not_a13 <= 1'b1;
    end else begin
      ppu_done <= 1'b0;
      case (ppu_state)
        P_IDLE: begin
          if (ppu_req && ppu_ready) begin
            ppu_addr    <= ppu_req_addr;
            ppu_not_a13 <= ~ppu_req_addr[13];
            ppu_rd      <= 1'b0;
            ppu_cnt     <= '0;
            ppu_ready   <= 1'b0;
            ppu_state   <= P_STROBE;
          end
        end
        P_STROBE: begin
          if (ppu_cnt == 2'd2) begin
            ppu_rd    <= 1'b1;
            ppu_rdata <= ppu_data_in;
            ppu_done  <= 1'b1;
            ppu_state <= P_RECOVER;
          end else begin
            ppu_cnt <= ppu_cnt + 2'd1;
          end
        end
        P_RECOVER: begin
          ppu_ready <= 1'b1;
          ppu_state <= P_IDLE;
        end
        default: ppu_state <= P_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_cart_bus_master.sv
// Self-checking bench for cart_bus_master: per-period transaction model vs. sampled pins.
// Build with CART_BUS_PPU_EN to also exercise the PPU strobe.
module tb_cart_bus_master;

  typedef struct {
    bit          v;
    bit          rw;
    logic [15:0] addr;
    logic [7:0]  wd;
  } txn_t;

  // {m2, ready, romsel, cpu_rw, cpu_addr, oe, data_out, done, rdata}
  localparam logic [36:0] RST_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 15'h0, 1'b0, 8'h00, 1'b0, 8'h00};

  logic        clk;
  logic        rst;
  logic        m2;
  logic        romsel;
  logic        cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in;
  logic [7:0]  lut [0:15];

  int errors = 0;
  int checks = 0;

  txn_t        q [$];
  txn_t        per [0:31];
  logic [36:0] obs [0:255];

  cart_bus_if bus ();

`ifdef CART_BUS_PPU_EN
  logic        ppu_req;
  logic        ppu_ready;
  logic [13:0] ppu_req_addr;
  logic        ppu_done;
  logic [7:0]  ppu_rdata;
  logic        ppu_rd;
  logic [13:0] ppu_addr;
  logic        ppu_not_a13;
  logic [7:0]  ppu_data_in;
`endif

  cart_bus_master dut (
    .clk          (clk),
    .rst          (rst),
    .host         (bus),
    .m2           (m2),
    .romsel       (romsel),
    .cpu_rw       (cpu_rw),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_data_oe  (cpu_data_oe),
    .cpu_data_in  (cpu_data_in)
`ifdef CART_BUS_PPU_EN
    ,
    .ppu_req      (ppu_req),
    .ppu_ready    (ppu_ready),
    .ppu_req_addr (ppu_req_addr),
    .ppu_done     (ppu_done),
    .ppu_rdata    (ppu_rdata),
    .ppu_rd       (ppu_rd),
    .ppu_addr     (ppu_addr),
    .ppu_not_a13  (ppu_not_a13),
    .ppu_data_in  (ppu_data_in)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cartridge model: read data is a fixed function of the address.
  function automatic logic [7:0] cart_data(input logic [14:0] a);
    return lut[a[3:0]] ^ a[14:7];
  endfunction

  assign cpu_data_in = cart_data(cpu_addr);

  function automatic logic [36:0] pins();
    return {m2, bus.ready, romsel, cpu_rw, cpu_addr, cpu_data_oe, cpu_data_out, bus.done, bus.rdata};
  endfunction

  // Expected pins at sample k (k clk edges after reset release), from the per-period schedule.
  function automatic logic [36:0] exp_at(input int k);
    int          n;
    int          p;
    txn_t        t;
    txn_t        pv;
    logic        e_rs;
    logic        e_rw;
    logic        e_oe;
    logic [14:0] e_addr;
    logic [7:0]  e_dout;
    logic [7:0]  e_rdata;
    bit          t_wr;
    bit          p_wr;
    n = k / 10;
    p = k % 10;
    t = per[n];
    pv = (n > 0) ? per[n-1] : per[0];
    t_wr = t.v && !t.rw;
    p_wr = (n > 0) && pv.v && !pv.rw;
    e_rs = !(t.v && t.addr[15] && p >= 5);
    e_rw = t.v ? t.rw : 1'b1;
    if (p >= 4)      e_oe = t_wr;
    else if (p == 0) e_oe = p_wr;
    else             e_oe = p_wr && t_wr;
    e_addr = '0;
    e_dout = '0;
    e_rdata = '0;
    for (int m = 0; m <= n; m++) begin
      if (per[m].v) e_addr = per[m].addr[14:0];
      if (per[m].v && !per[m].rw && 10 * m + 4 <= k) e_dout = per[m].wd;
      if (per[m].v && per[m].rw && 10 * (m + 1) <= k) e_rdata = cart_data(per[m].addr[14:0]);
    end
    return {(p >= 4), (p == 9), e_rs, e_rw, e_addr, e_oe, e_dout,
            (p == 0 && n > 0 && pv.v), e_rdata};
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    bus.req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Sample pins at each negedge and feed queued requests; each queue entry owns one M2 period.
  task automatic run(input int nsamp);
    txn_t idle;
    idle = '{v: 1'b0, rw: 1'b1, addr: 16'h0, wd: 8'h0};
    for (int i = 0; i < 32; i++) per[i] = idle;
    for (int k = 0; k < nsamp; k++) begin
      if (k > 0) @(negedge clk);
      obs[k] = pins();
      if (q.size() > 0) begin
        bus.req       = q[0].v;
        bus.req_rw    = q[0].rw;
        bus.req_addr  = q[0].addr;
        bus.req_wdata = q[0].wd;
      end else begin
        bus.req = 1'b0;
      end
      if ((k + 1) % 10 == 0) per[(k + 1) / 10] = (q.size() > 0) ? q.pop_front() : idle;
    end
    bus.req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pins() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", pins(), RST_VEC);
    end
    apply_reset();
    run(12);
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (obs[k] !== exp_at(k)) begin
        errors++;
        $display("FAIL reset_release k=%0d got=%h exp=%h", k, obs[k], exp_at(k));
      end
    end
  endtask

  task automatic test_idle();
    apply_reset();
    run(30);
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (obs[k] !== exp_at(k)) begin
        errors++;
        $display("FAIL idle k=%0d got=%h exp=%h", k, obs[k], exp_at(k));
      end
    end
  endtask

  task automatic test_read_rom();
    int lows;
    lut[0] = 8'hA5;
    apply_reset();
    q.push_back('{v: 1'b1, rw: 1'b1, addr: 16'h8000, wd: 8'h00});
    run(30);
    lows = 0;
    for (int k = 0; k < 30; k++) begin
      if (!obs[k][34]) lows++;
      checks++;
      if (obs[k] !== exp_at(k)) begin
        errors++;
        $display("FAIL read_rom k=%0d got=%h exp=%h", k, obs[k], exp_at(k));
      end
    end
    checks++;
    if (lows !== 5) begin
      errors++;
      $display("FAIL read_rom_romsel_len got=%0d exp=5", lows);
    end
    checks++;
    if (obs[29][7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL read_rom_rdata got=%h exp=a5", obs[29][7:0]);
    end
  endtask

  task automatic test_write();
    int oes;
    apply_reset();
    q.push_back('{v: 1'b1, rw: 1'b0, addr: 16'h6000, wd: 8'h3C});
    run(30);
    oes = 0;
    for (int k = 0; k < 30; k++) begin
      if (obs[k][17]) oes++;
      checks++;
      if (obs[k] !== exp_at(k)) begin
        errors++;
        $display("FAIL write k=%0d got=%h exp=%h", k, obs[k], exp_at(k));
      end
    end
    checks++;
    if (oes !== 7) begin
      errors++;
      $display("FAIL write_oe_len got=%0d exp=7", oes);
    end
  endtask

  task automatic test_back_to_back();
    int          dones;
    logic [7:0]  got [$];
    for (int i = 0; i < 4; i++)
      q.push_back('{v: 1'b1, rw: 1'b1, addr: 16'h8000 + 16'(i), wd: 8'h00});
    apply_reset();
    run(60);
    dones = 0;
    for (int k = 0; k < 60; k++) begin
      if (obs[k][8]) begin
        dones++;
        got.push_back(obs[k][7:0]);
      end
      checks++;
      if (obs[k] !== exp_at(k)) begin
        errors++;
        $display("FAIL back_to_back k=%0d got=%h exp=%h", k, obs[k], exp_at(k));
      end
    end
    checks++;
    if (dones !== 4) begin
      errors++;
      $display("FAIL back_to_back_dones got=%0d exp=4", dones);
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== cart_data(15'(i))) begin
        errors++;
        $display("FAIL back_to_back_order i=%0d got=%h exp=%h", i, got[i], cart_data(15'(i)));
      end
    end
  endtask

  task automatic test_random();
    txn_t t;
    for (int i = 0; i < 16; i++) begin
      t.v    = ($urandom_range(0, 4) != 0);
      t.rw   = 1'($urandom_range(0, 1));
      t.addr = 16'($urandom);
      t.wd   = 8'($urandom);
      q.push_back(t);
    end
    apply_reset();
    run(180);
    for (int k = 0; k < 180; k++) begin
      checks++;
      if (obs[k] !== exp_at(k)) begin
        errors++;
        $display("FAIL random k=%0d got=%h exp=%h", k, obs[k], exp_at(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    apply_reset();
    q.push_back('{v: 1'b1, rw: 1'b0, addr: 16'hC000, wd: 8'h77});
    run(17);
    for (int k = 0; k < 17; k++) begin
      checks++;
      if (obs[k] !== exp_at(k)) begin
        errors++;
        $display("FAIL reset_mid_pre k=%0d got=%h exp=%h", k, obs[k], exp_at(k));
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pins() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_mid_async got=%h exp=%h", pins(), RST_VEC);
    end
    apply_reset();
    q.push_back('{v: 1'b1, rw: 1'b1, addr: 16'h8001, wd: 8'h00});
    run(30);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      if (k < 10 && obs[k][8]) dones++;
      checks++;
      if (obs[k] !== exp_at(k)) begin
        errors++;
        $display("FAIL reset_mid_post k=%0d got=%h exp=%h", k, obs[k], exp_at(k));
      end
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got=%0d exp=0", dones);
    end
  endtask

`ifdef CART_BUS_PPU_EN
  task automatic ppu_seq();
    int dones;
    int lows;
    repeat (3) @(negedge clk);
    ppu_req_addr = 14'h2005;
    ppu_data_in  = 8'h5A;
    ppu_req      = 1'b1;
    checks++;
    if (ppu_ready !== 1'b1) begin
      errors++;
      $display("FAIL ppu_ready_idle got=%b exp=1", ppu_ready);
    end
    dones = 0;
    lows = 0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      ppu_req = 1'b0;
      if (!ppu_rd) lows++;
      if (ppu_done) dones++;
      checks++;
      if (ppu_rd !== (j >= 3) || ppu_done !== (j == 3) || ppu_ready !== (j >= 4)) begin
        errors++;
        $display("FAIL ppu_timing j=%0d got rd=%b done=%b rdy=%b exp rd=%b done=%b rdy=%b",
                 j, ppu_rd, ppu_done, ppu_ready, (j >= 3), (j == 3), (j >= 4));
      end
      if (j == 0) begin
        checks++;
        if (ppu_addr !== 14'h2005 || ppu_not_a13 !== 1'b0) begin
          errors++;
          $display("FAIL ppu_addr got=%h/%b exp=2005/0", ppu_addr, ppu_not_a13);
        end
      end
      if (j == 3) begin
        checks++;
        if (ppu_rdata !== 8'h5A) begin
          errors++;
          $display("FAIL ppu_rdata got=%h exp=5a", ppu_rdata);
        end
      end
    end
    checks++;
    if (lows !== 3 || dones !== 1) begin
      errors++;
      $display("FAIL ppu_counts got lows=%0d dones=%0d exp 3/1", lows, dones);
    end
  endtask

  task automatic test_ppu();
    apply_reset();
    q.push_back('{v: 1'b1, rw: 1'b1, addr: 16'h8000, wd: 8'h00});
    fork
      run(30);
      ppu_seq();
    join
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (obs[k] !== exp_at(k)) begin
        errors++;
        $display("FAIL ppu_cpu k=%0d got=%h exp=%h", k, obs[k], exp_at(k));
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.req = 1'b0;
    bus.req_rw = 1'b1;
    bus.req_addr = '0;
    bus.req_wdata = '0;
`ifdef CART_BUS_PPU_EN
    ppu_req = 1'b0;
    ppu_req_addr = '0;
    ppu_data_in = '0;
`endif
    for (int i = 0; i < 16; i++) lut[i] = 8'($urandom);
    test_reset();
    test_idle();
    test_read_rom();
    test_write();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef CART_BUS_PPU_EN
    test_ppu();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
